// File: rtl/dmem_responder_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Misaligned, illegal-size or out-of-range accesses are rejected without touching memory.
  function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr,
                                      input int unsigned addr_w);
    logic err;
    err = 1'b0;
    if (size == SIZE_BAD) err = 1'b1;
    if (size == SIZE_HALF && addr[0]) err = 1'b1;
    if (size == SIZE_WORD && addr[1:0] != 2'b00) err = 1'b1;
    if ((addr >> (addr_w + 2)) != 32'h0) err = 1'b1;
    return err;
  endfunction

endpackage

// File: rtl/dmem_responder_bram.sv
// Byte-enabled word RAM with synchronous write and registered read.
module dmem_bram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              wr,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Read port only updates on loads so the last read word holds across stores.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wr) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU data port: req/addr_ok/data_ok handshake,
// programmable wait states, full-word read return.
//
// state   | meaning
// IDLE    | no access in flight, ready to accept
// BUSY    | access accepted, counting wait states; commit on last cycle
// RESP    | data_ok pulse; may accept the next request
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        data_err
);

  localparam logic [3:0] Lat = 4'(LATENCY);

  state_e      state;
  state_e      state_nxt;
  logic [3:0]  cnt;
  logic        accept;
  logic        commit;
  logic        acc_err;
  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic        rd_ok;
  logic        err_q;
  logic [31:0] ram_q;

  assign accept  = data_req & data_addr_ok;
  assign acc_err = access_err(size_q, addr_q, ADDR_W);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_BUSY;
      ST_BUSY: if (cnt == 4'd1) state_nxt = ST_RESP;
      ST_RESP: state_nxt = accept ? ST_BUSY : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset on the commit edge wins, so commit is masked by rst.
  always_comb begin
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    commit       = 1'b0;
    case (state)
      ST_IDLE: data_addr_ok = !rst;
      ST_BUSY: commit = (cnt == 4'd1) && !rst;
      ST_RESP: begin
        data_addr_ok = !rst;
        data_data_ok = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                               cnt <= 4'd0;
    else if (accept)                       cnt <= Lat;
    else if (state == ST_BUSY && cnt != 0) cnt <= cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      size_q  <= SIZE_WORD;
      addr_q  <= 32'h0;
      wstrb_q <= 4'h0;
      wdata_q <= 32'h0;
    end else if (accept) begin
      wr_q    <= data_wr;
      size_q  <= data_size;
      addr_q  <= data_addr;
      wstrb_q <= data_wstrb;
      wdata_q <= data_wdata;
    end
  end

  // rd_ok gates the RAM output so reset and errors present a zero word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ok <= 1'b0;
      err_q <= 1'b0;
    end else if (commit) begin
      err_q <= acc_err;
      if (acc_err)    rd_ok <= 1'b0;
      else if (!wr_q) rd_ok <= 1'b1;
    end
  end

  dmem_bram #(.ADDR_W(ADDR_W)) u_bram (
    .clk   (clk),
    .en    (commit & !acc_err),
    .wr    (wr_q),
    .be    (wstrb_q),
    .addr  (addr_q[ADDR_W+1:2]),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  assign data_rdata = rd_ok ? ram_q : ZeroWord;
  assign data_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table on a LATENCY=2 instance,
// reset corner sequences, and a random scoreboard run on a LATENCY=1 instance.
module tb_dmem_responder;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic        f_wr = 1'b0;
  logic [1:0]  f_size = 2'b10;
  logic [31:0] f_addr = 32'h0;
  logic [3:0]  f_strb = 4'h0;
  logic [31:0] f_wdata = 32'h0;
  logic [1:0]  addr_ok;
  logic [1:0]  data_ok;
  logic [1:0]  err;
  logic [31:0] rdata [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(12), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_req(req[0]), .data_wr(f_wr), .data_size(f_size),
    .data_addr(f_addr), .data_wstrb(f_strb), .data_wdata(f_wdata),
    .data_addr_ok(addr_ok[0]), .data_data_ok(data_ok[0]), .data_rdata(rdata[0]),
    .data_err(err[0])
  );

  dmem_responder #(.ADDR_W(12), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .data_req(req[1]), .data_wr(f_wr), .data_size(f_size),
    .data_addr(f_addr), .data_wstrb(f_strb), .data_wdata(f_wdata),
    .data_addr_ok(addr_ok[1]), .data_data_ok(data_ok[1]), .data_rdata(rdata[1]),
    .data_err(err[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the response cycle (or after a timeout).
  task automatic xfer(input int d, input logic wr, input logic [1:0] size,
                      input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata,
                      output logic got_err, output logic [31:0] got_rd,
                      output int waits, output int lat);
    f_wr = wr; f_size = size; f_addr = addr; f_strb = strb; f_wdata = wdata;
    req[d] = 1'b1;
    waits = 0;
    lat = -1;
    got_err = 1'bx;
    got_rd = 'x;
    while (!addr_ok[d] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (addr_ok[d]) begin
      @(posedge clk);
      #1 req[d] = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (data_ok[d]) begin
          lat = k;
          break;
        end
      end
      got_err = err[d];
      got_rd = rdata[d];
    end else begin
      req[d] = 1'b0;
    end
  endtask

  // Issue a store to the LATENCY=2 instance and pulse rst for one cycle after `delay` busy cycles.
  task automatic store_with_reset(input logic [31:0] addr, input logic [31:0] wdata,
                                  input int delay, input string tag);
    int seen;
    f_wr = 1'b1; f_size = 2'b10; f_addr = addr; f_strb = 4'hF; f_wdata = wdata;
    req[0] = 1'b1;
    check({tag, "_addr_ok_before"}, 32'(addr_ok[0]), 32'h1);
    @(posedge clk);
    #1 req[0] = 1'b0;
    repeat (delay) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check({tag, "_addr_ok_in_rst"}, 32'(addr_ok[0]), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check({tag, "_addr_ok_after_rst"}, 32'(addr_ok[0]), 32'h1);
    check({tag, "_rdata_after_rst"}, rdata[0], 32'h0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (data_ok[0]) seen++;
      @(negedge clk);
    end
    check({tag, "_no_data_ok"}, 32'(seen), 32'h0);
  endtask

  vec_t tbl[$];
  logic [31:0] model [16];

  initial begin
    logic        g_err;
    logic [31:0] g_rd;
    int          waits;
    int          lat;
    time         t0;

    tbl.push_back('{1'b1, 2'b10, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h10, 4'b0000, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{1'b1, 2'b00, 32'h11, 4'b0010, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h10, 4'b0000, 32'h0,        1'b0, 1'b1, 32'hDEAD5AEF});
    tbl.push_back('{1'b1, 2'b01, 32'h12, 4'b1100, 32'h12341234, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h10, 4'b0000, 32'h0,        1'b0, 1'b1, 32'h12345AEF});
    tbl.push_back('{1'b1, 2'b10, 32'h00, 4'b1111, 32'h01020304, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b1, 2'b10, 32'h20, 4'b1111, 32'h11223344, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h13, 4'b0000, 32'h0,        1'b1, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 2'b10, 32'h00400000, 4'b1111, 32'hCAFEF00D, 1'b1, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h00, 4'b0000, 32'h0,        1'b0, 1'b1, 32'h01020304});
    tbl.push_back('{1'b0, 2'b11, 32'h10, 4'b0000, 32'h0,        1'b1, 1'b1, 32'h0});
    tbl.push_back('{1'b0, 2'b01, 32'h11, 4'b0000, 32'h0,        1'b1, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 2'b11, 32'h10, 4'b1111, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0});
    tbl.push_back('{1'b1, 2'b10, 32'h10, 4'b0000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0});
    tbl.push_back('{1'b0, 2'b10, 32'h10, 4'b0000, 32'h0,        1'b0, 1'b1, 32'h12345AEF});
    tbl.push_back('{1'b0, 2'b01, 32'h12, 4'b0000, 32'h0,        1'b0, 1'b1, 32'h12345AEF});
    tbl.push_back('{1'b0, 2'b00, 32'h13, 4'b0000, 32'h0,        1'b0, 1'b1, 32'h12345AEF});

    repeat (3) @(negedge clk);
    check("rst_addr_ok", 32'(addr_ok[0]), 32'h0);
    check("rst_data_ok", 32'(data_ok[0]), 32'h0);
    check("rst_rdata", rdata[0], 32'h0);
    check("rst_err", 32'(err[0]), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_addr_ok", 32'(addr_ok[0]), 32'h1);

    // Vectors run back-to-back: each one is issued in the previous one's RESP cycle.
    for (int i = 0; i < tbl.size(); i++) begin
      xfer(0, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].strb, tbl[i].wdata,
           g_err, g_rd, waits, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_err", i), 32'(g_err), 32'(tbl[i].exp_err));
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), g_rd, tbl[i].exp_rd);
      if (i > 0) check($sformatf("vec%0d_b2b_accept", i), 32'(waits), 32'd0);
    end

    @(negedge clk);
    store_with_reset(32'h20, 32'hFFFFFFFF, 0, "rst_busy");
    xfer(0, 1'b0, 2'b10, 32'h20, 4'h0, 32'h0, g_err, g_rd, waits, lat);
    check("rst_busy_readback", g_rd, 32'h11223344);
    check("rst_busy_readback_lat", 32'(lat), 32'd3);

    @(negedge clk);
    store_with_reset(32'h20, 32'hFFFFFFFF, 1, "rst_commit");
    xfer(0, 1'b0, 2'b10, 32'h20, 4'h0, 32'h0, g_err, g_rd, waits, lat);
    check("rst_commit_readback", g_rd, 32'h11223344);
    check("rst_commit_readback_err", 32'(g_err), 32'h0);

    // LATENCY=1 instance: preload a 16-word window, then random traffic against a byte model.
    for (int w = 0; w < 16; w++) begin
      model[w] = $urandom;
      xfer(1, 1'b1, 2'b10, 32'(w * 4), 4'hF, model[w], g_err, g_rd, waits, lat);
      check($sformatf("init%0d_latency", w), 32'(lat), 32'd2);
    end
    t0 = $time;
    for (int n = 0; n < 50; n++) begin
      int          w;
      int          sz;
      int          ofs;
      logic        wr;
      logic [31:0] d;
      logic [31:0] wd;
      logic [3:0]  st;
      w  = $urandom_range(0, 15);
      sz = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      if (sz == 0) begin
        ofs = $urandom_range(0, 3);
        wd = {4{d[7:0]}};
        st = 4'(4'b0001 << ofs);
      end else if (sz == 1) begin
        ofs = 2 * $urandom_range(0, 1);
        wd = {2{d[15:0]}};
        st = 4'(4'b0011 << ofs);
      end else begin
        ofs = 0;
        wd = d;
        st = 4'hF;
      end
      xfer(1, wr, 2'(sz), 32'(w * 4 + ofs), wr ? st : 4'h0, wd, g_err, g_rd, waits, lat);
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'd2);
      check($sformatf("rnd%0d_accept_wait", n), 32'(waits), 32'd0);
      check($sformatf("rnd%0d_err", n), 32'(g_err), 32'h0);
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (st[b]) model[w][8*b +: 8] = wd[8*b +: 8];
      end else begin
        check($sformatf("rnd%0d_rdata", n), g_rd, model[w]);
      end
    end
    check("rnd_throughput_cycles", 32'(($time - t0) / 10), 32'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the CPU data port. It accepts the byte-strobe requests produced by the memory-stage access formatter (addr, size, 4-bit byte select, lane-replicated write data) over an SRAM-like req/addr_ok/data_ok handshake. It performs the access on an internal byte-enabled word RAM with programmable wait states, and returns the full 32-bit word; byte and halfword extraction stays on the CPU side. It sits between the CPU data port and on-chip data memory, and doubles as a slow-memory model for stall testing.

## Interface
- ADDR_W, 12, word-index width; memory holds 2^ADDR_W 32-bit words
- LATENCY, 2, wait cycles between accept and response; legal range 1..15
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- data_req  in  1  request valid
- data_wr  in  1  1 = store, 0 = load
- data_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- data_addr  in  32  byte address
- data_wstrb  in  4  byte-lane enables for stores; ignored for loads
- data_wdata  in  32  store data, already lane-replicated by requester
- data_addr_ok  out  1  request accepted this cycle when high with data_req
- data_data_ok  out  1  one-cycle response pulse
- data_rdata  out  32  full read word, valid with data_data_ok
- data_err  out  1  error flag, valid with data_data_ok

## Operation
- FSM states: IDLE, BUSY, RESP.
- data_addr_ok = (state==IDLE or state==RESP) and !rst; combinational from state only, never from data_req.
- Accept = data_req & data_addr_ok. On accept: latch wr, size, addr, wstrb, wdata; load wait counter with LATENCY; go to BUSY.
- BUSY: decrement counter each cycle. In the last BUSY cycle (counter==1), commit the access at the closing edge and go to RESP.
- Load commit: data_rdata <= mem[addr[ADDR_W+1:2]].
- Store commit: for each lane i with wstrb[i]=1, write byte i of mem from wdata byte i. Lanes with wstrb=0 are unchanged. wstrb=0000 is a legal no-op store.
- RESP: data_data_ok=1 for exactly one cycle. A new accept in RESP goes straight to BUSY; otherwise the FSM returns to IDLE.
- Error is evaluated on latched fields. Any of the following sets the error:
  - size==11
  - size==01 with addr[0]=1
  - size==10 with addr[1:0]!=00
  - addr[31:ADDR_W+2] nonzero
- On error: no memory write; data_rdata=0; data_err=1 in RESP; timing is unchanged.
- data_err and data_rdata hold their values until the next commit. The requester must sample them only with data_data_ok.
- The memory array is not cleared by rst.

## Timing
- Accept in cycle t. BUSY in cycles t+1..t+LATENCY. data_data_ok high in cycle t+LATENCY+1.
- Back-to-back issue: the next accept is possible in the RESP cycle, giving one access every LATENCY+1 cycles.
- Read-after-write: a store commits before its RESP cycle, so a load accepted in that RESP cycle returns the new data.
- Reset values: state IDLE, counter 0, data_addr_ok 0 while rst is high, data_data_ok 0, data_rdata 0, data_err 0.
- Reset mid-operation:
  - Rst in BUSY before the commit edge aborts the access: no write, no data_ok.
  - Rst in the commit cycle has priority, so the write is suppressed.
  - The first accept is possible in the cycle after rst deasserts.
- data_req held while data_addr_ok=0 is simply not accepted; the requester keeps its fields stable until accepted.

## Structure
- Shared defines header entries:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - FSM state encodings ST_IDLE/ST_BUSY/ST_RESP
  - ZeroWord (already defined)
- One sub-module, dmem_bram: 2^ADDR_W x 32 RAM.
  - Synchronous per-byte write enable and registered read.
  - Must infer block RAM.
  - The FSM drives its enable only on the commit edge.
- The FSM, latch registers, counter and error check live in dmem_responder.

## Test plan
- Reset then word store/load, LATENCY=2:
  - SW addr 0x10, wdata 0xDEADBEEF, wstrb 1111 -> data_ok at t+3, err 0.
  - LW 0x10 -> data_rdata 0xDEADBEEF.
- Byte lanes: after the word store above, SB addr 0x11, wdata 0x5A5A5A5A, wstrb 0010; then LW 0x10 -> 0xDEAD5AEF.
- Halfword store plus back-to-back load:
  - SH addr 0x12, wdata 0x12341234, wstrb 1100 (0x10 still 0xDEAD5AEF).
  - LW 0x10 issued in the store's RESP cycle -> accepted; data_ok 3 cycles later with 0x12345AEF.
- Errors:
  - LW addr 0x13 -> data_err 1, rdata 0.
  - SW addr 0x00400000 (ADDR_W=12) -> data_err 1; memory unchanged.
  - size 11 -> data_err 1.
- Reset mid-flight: SW 0x20 data 0xFFFFFFFF, rst pulsed in the first BUSY cycle -> no data_ok; after reset, LW 0x20 returns the prior value.
- LATENCY=1 stress: 50 random aligned requests issued as soon as addr_ok; check against a scoreboard model; data_ok exactly every 2 cycles.
